// File: rtl/rotsq_pkg.sv
// Shared constants, mode encoding and the position-to-segment decoder
// for the rotating-square display driver.
package rotsq_pkg;

    localparam logic [6:0] SEG_TOP = 7'b0011100;
    localparam logic [6:0] SEG_BTM = 7'b0100011;

    localparam int unsigned MAX_NDIG  = 16;
    localparam int unsigned POS_IDX_W = 5;

    typedef enum logic [1:0] {
        MODE_CIRCLE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2
    } mode_e;

    // Cathodes sit in the LSBs so a caller can truncate to 7+NDIG bits.
    typedef struct packed {
        logic [MAX_NDIG-1:0] an;
        logic [6:0]          ca;
    } seg_out_t;

    function automatic seg_out_t decode_pos(input logic [POS_IDX_W-1:0] pos,
                                            input int unsigned ndig);
        seg_out_t    r;
        int unsigned p;
        int unsigned idx;
        p    = 32'(pos);
        r.an = '1;
        r.ca = SEG_BTM;
        if (p < ndig) begin
            idx = ndig - 1 - p;
        end else begin
            r.ca = SEG_TOP;
            idx  = p - ndig;
        end
        if (idx < MAX_NDIG) begin
            r.an[idx[3:0]] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/rotating_square_gen_tick_gen.sv
// Clock-enable prescaler: one-cycle tick every 2^(MIN_SHIFT+speed) clocks while run=1.
module tick_gen #(
    parameter int unsigned DIV_W     = 27,
    parameter int unsigned MIN_SHIFT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] speed,
    output logic       tick
);

    if (MIN_SHIFT + 7 > DIV_W) begin : g_bad_width
        $error("tick_gen: MIN_SHIFT+7 must not exceed DIV_W");
    end

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] limit_c;

    assign limit_c = (DIV_W'(1) << (MIN_SHIFT + 32'(speed))) - DIV_W'(1);

    // >= so a speed drop below the current count fires at once and clears.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count >= limit_c) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + DIV_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/rotating_square_gen.sv
// Walks a lit half-digit square around an NDIG-digit seven-segment display
// with circle, bounce and blink modes, runtime speed and single-step.
module rotating_square_gen
    import rotsq_pkg::*;
#(
    parameter int unsigned NDIG      = 8,
    parameter int unsigned DIV_W     = 27,
    parameter int unsigned MIN_SHIFT = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          cw,
    input  logic [1:0]                    mode,
    input  logic [2:0]                    speed,
    input  logic                          step,
    output logic [6:0]                    CA,
    output logic [NDIG-1:0]               AN,
    output logic [$clog2(2*NDIG)-1:0]     pos,
    output logic                          wrap
);

    localparam int unsigned PW = $clog2(2*NDIG);
    localparam int unsigned SW = 7 + NDIG;
    localparam logic [PW-1:0] POS_MAX = PW'(2*NDIG - 1);

    if (NDIG < 2 || NDIG > MAX_NDIG) begin : g_bad_ndig
        $error("rotating_square_gen: NDIG must be in 2..16");
    end

    logic          tick;
    logic          adv_c;
    logic          dir;
    logic          dir_nxt;
    logic          blank;
    logic          blank_nxt;
    logic          wrap_nxt;
    logic [PW-1:0] pos_nxt;
    logic [SW-1:0] seg_c;
    mode_e         mode_c;
    mode_e         prev_mode;

    tick_gen #(
        .DIV_W     (DIV_W),
        .MIN_SHIFT (MIN_SHIFT)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .run   (en),
        .speed (speed),
        .tick  (tick)
    );

    // Next position/direction/blank; dir is (re)loaded from cw on bounce entry.
    always_comb begin
        mode_c    = (mode == 2'd3) ? MODE_CIRCLE : mode_e'(mode);
        adv_c     = en ? tick : step;
        dir_nxt   = (mode_c == MODE_BOUNCE && prev_mode != MODE_BOUNCE) ? cw : dir;
        pos_nxt   = pos;
        wrap_nxt  = 1'b0;
        blank_nxt = (mode_c == MODE_BLINK) ? blank : 1'b0;
        seg_c     = SW'(decode_pos(POS_IDX_W'(pos), NDIG));
        if (adv_c) begin
            case (mode_c)
                MODE_BOUNCE: begin
                    if (!dir_nxt) begin
                        if (pos == POS_MAX) begin
                            dir_nxt  = 1'b1;
                            pos_nxt  = pos - PW'(1);
                            wrap_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos + PW'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_nxt  = 1'b0;
                            pos_nxt  = PW'(1);
                            wrap_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos - PW'(1);
                        end
                    end
                end
                MODE_BLINK: begin
                    blank_nxt = ~blank;
                end
                default: begin
                    if (cw) begin
                        pos_nxt  = (pos == '0) ? POS_MAX : pos - PW'(1);
                        wrap_nxt = (pos == '0);
                    end else begin
                        pos_nxt  = (pos == POS_MAX) ? '0 : pos + PW'(1);
                        wrap_nxt = (pos == POS_MAX);
                    end
                end
            endcase
        end
    end

    // Display outputs follow the registered position by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos       <= '0;
            dir       <= 1'b0;
            blank     <= 1'b0;
            wrap      <= 1'b0;
            prev_mode <= MODE_CIRCLE;
            CA        <= SEG_BTM;
            AN        <= ~(NDIG'(1) << (NDIG - 1));
        end else begin
            pos       <= pos_nxt;
            dir       <= dir_nxt;
            blank     <= blank_nxt;
            wrap      <= wrap_nxt;
            prev_mode <= mode_c;
            CA        <= seg_c[6:0];
            AN        <= blank ? '1 : seg_c[SW-1:7];
        end
    end

endmodule
